// File: rtl/lab2_sweep_checker.sv
// Clocked stimulus/response sweep for the 3-input lab2 circuit: drives every input
// vector, captures the truth table and counts differences from EXP_TABLE. Define
// SWEEP_GRAY_EN to apply the vectors in Gray-code order instead of binary order.
module lab2_sweep_checker #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2,
    parameter logic [2**N_IN-1:0] EXP_TABLE = 8'b1000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   truth_table,
    output logic [N_IN:0]        err_count,
    output logic                 mismatch
);
    localparam int NV = 2**N_IN;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t              state_q;
    logic [N_IN-1:0]     idx_q;
    logic [N_IN-1:0]     dut_in_q;
    logic [3:0]          cnt_q;
    logic [NV-1:0]       table_q;
    logic [N_IN:0]       err_q;
    logic                busy_q;
    logic                done_q;
    logic                mismatch_q;

    logic [N_IN-1:0]     idx_d;
    logic [N_IN-1:0]     vec_d;
    logic [N_IN:0]       err_d;
    logic                last_vec;
    logic                sample_bad;

    // idx_q is the sweep position; the vector actually driven is derived from it.
    always_comb begin
        idx_d = idx_q + 1'b1;
`ifdef SWEEP_GRAY_EN
        vec_d = idx_d ^ (idx_d >> 1);
`else
        vec_d = idx_d;
`endif
        last_vec   = (idx_q == N_IN'(NV - 1));
        sample_bad = (dut_out != EXP_TABLE[dut_in_q]);
        err_d      = sample_bad ? err_q + 1'b1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            dut_in_q   <= '0;
            cnt_q      <= '0;
            table_q    <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= DRIVE;
                        idx_q      <= '0;
                        dut_in_q   <= '0;
                        cnt_q      <= '0;
                        table_q    <= '0;
                        err_q      <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        mismatch_q <= 1'b0;
                    end
                end
                DRIVE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == 4'(SETTLE - 1)) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    table_q[dut_in_q] <= dut_out;
                    err_q             <= err_d;
                    if (last_vec) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        mismatch_q <= (err_d != '0);
                    end else begin
                        state_q  <= DRIVE;
                        idx_q    <= idx_d;
                        dut_in_q <= vec_d;
                        cnt_q    <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dut_in      = dut_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = table_q;
    assign err_count   = err_q;
    assign mismatch    = mismatch_q;

endmodule

// File: tb/tb_lab2_sweep_checker.sv
// Directed bench for lab2_sweep_checker: AND and XOR circuits on the default build,
// mid-sweep reset, start held high, restart from DONE, and a SETTLE=1 instance.
module tb_lab2_sweep_checker;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start1;
    logic       sel_xor;
    logic [2:0] dut_in, dut_in1;
    logic       dut_out, dut_out1;
    logic       busy, done, mismatch;
    logic       busy1, done1, mismatch1;
    logic [7:0] truth_table, truth_table1;
    logic [3:0] err_count, err_count1;

    int total = 0;
    int bad   = 0;

`ifdef SWEEP_GRAY_EN
    int exp_seq [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
`else
    int exp_seq [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    always #5 clk = ~clk;

    // The circuit under test: 3-input AND, or 3-input XOR when sel_xor is set.
    assign dut_out  = sel_xor ? ^dut_in : &dut_in;
    assign dut_out1 = &dut_in1;

    lab2_sweep_checker dut (
        .clk(clk), .rst(rst), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .truth_table(truth_table),
        .err_count(err_count), .mismatch(mismatch)
    );

    lab2_sweep_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
        .busy(busy1), .done(done1), .truth_table(truth_table1),
        .err_count(err_count1), .mismatch(mismatch1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full sweep on the default-settle instance; start is left high if hold_start.
    task automatic sweep(input string nm, input logic [7:0] exp_tt, input int exp_err,
                         input bit hold_start);
        logic [2:0] prev;
        prev  = '0;
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        check({nm, "_busy_start"}, 32'(busy), 32'd1);
        check({nm, "_tt_cleared"}, 32'(truth_table), 32'd0);
        for (int v = 0; v < 8; v++) begin
            check({nm, "_vec"}, 32'(dut_in), 32'(exp_seq[v]));
`ifdef SWEEP_GRAY_EN
            if (v > 0) check({nm, "_hamming"}, 32'($countones(prev ^ dut_in)), 32'd1);
`endif
            prev = dut_in;
            for (int s = 0; s < 3; s++) begin
                tick();
                if (v == 7 && s == 1) check({nm, "_done_early"}, 32'(done), 32'd0);
            end
        end
        check({nm, "_done"}, 32'(done), 32'd1);
        check({nm, "_busy_end"}, 32'(busy), 32'd0);
        check({nm, "_tt"}, 32'(truth_table), 32'(exp_tt));
        check({nm, "_err"}, 32'(err_count), 32'(exp_err));
        check({nm, "_mismatch"}, 32'(mismatch), (exp_err != 0) ? 32'd1 : 32'd0);
        check({nm, "_last_vec"}, 32'(dut_in), 32'(exp_seq[7]));
        $display("sweep %s: tt=%02h err=%0d mm=%0b", nm, truth_table, err_count, mismatch);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0; sel_xor = 1'b0;
        tick(); tick();
        check("rst_dut_in", 32'(dut_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tt", 32'(truth_table), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_mm", 32'(mismatch), 32'd0);
        rst = 1'b0;
        tick();

        sweep("and", 8'h80, 0, 1'b0);
        tick();
        check("done_hold", 32'(done), 32'd1);

        // Vectors 1, 2 and 4 give 1 against an expected 0; vector 7 agrees.
        sel_xor = 1'b1;
        sweep("xor", 8'h96, 3, 1'b0);
        sel_xor = 1'b0;

        start = 1'b1; tick(); start = 1'b0;
        repeat (9) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_dut_in", 32'(dut_in), 32'd0);
        check("midrst_tt", 32'(truth_table), 32'd0);
        check("midrst_err", 32'(err_count), 32'd0);
        repeat (3) tick();
        check("midrst_idle", 32'(busy), 32'd0);
        $display("sweep midrst: reset applied on cycle 10");
        sweep("after_rst", 8'h80, 0, 1'b0);

        sweep("held", 8'h80, 0, 1'b1);
        tick();
        check("restart_done", 32'(done), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_tt", 32'(truth_table), 32'd0);
        check("restart_err", 32'(err_count), 32'd0);
        start = 1'b0;
        $display("sweep restart: done fell on the restart edge");
        rst = 1'b1; tick(); rst = 1'b0;

        start1 = 1'b1; tick(); start1 = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 15) check("s1_done_early", 32'(done1), 32'd0);
        end
        check("s1_done", 32'(done1), 32'd1);
        check("s1_tt", 32'(truth_table1), 32'h80);
        check("s1_err", 32'(err_count1), 32'd0);
        check("s1_last_vec", 32'(dut_in1), 32'(exp_seq[7]));
        $display("sweep settle1: tt=%02h err=%0d", truth_table1, err_count1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
